fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_pc_reg.sv | 33 +++
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core package for the fetch unit: FSM state encoding, instruction width,
// the NOP constant and address helpers.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP    = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Drop the byte offset of a redirect target; fetches are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr & ~ALIGN_MASK) != 32'h0000_0000;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: holds, steps by one word (wrapping at 2^32) or loads an
// aligned redirect target; a redirect wins over the sequential step.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_r;

  // PC update: reset, redirect, sequential step, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= word_align(target);
    end else if (advance) begin
      pc_r <= pc_r + PC_STEP;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, one-entry redirect
// buffer, registered instruction output. Optional trap flag: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic [XLEN-1:0] ALUResult,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  fetch_state_e    state_r;
  fetch_state_e    state_s;
  logic            imem_req_r;
  logic            req_s;

  logic [XLEN-1:0] pc_s;
  logic            pc_load_s;
  logic            pc_adv_s;
  logic [XLEN-1:0] pc_tgt_s;

  logic            capture_s;
  logic            clr_valid_s;
  logic            pend_set_s;
  logic            pend_clr_s;

  logic            redir_pend_r;
  logic [XLEN-1:0] redir_tgt_r;
  logic [ILEN-1:0] instr_r;
  logic [XLEN-1:0] instr_pc_r;
  logic            instr_valid_r;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load_s),
    .target  (pc_tgt_s),
    .advance (pc_adv_s),
    .pc      (pc_s)
  );

  // FSM state and registered request strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      imem_req_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      imem_req_r <= req_s;
    end
  end

  // Next state and datapath controls; a branch always outranks ready and ack
  always_comb begin
    state_s     = state_r;
    pc_load_s   = 1'b0;
    pc_adv_s    = 1'b0;
    pc_tgt_s    = ALUResult;
    capture_s   = 1'b0;
    clr_valid_s = 1'b0;
    pend_set_s  = 1'b0;
    pend_clr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_REQ;
        if (branch) begin
          pc_load_s = 1'b1;
        end else begin
          pc_load_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          if (branch || redir_pend_r) begin
            // Returned word belongs to a squashed path: drop it, re-request at newest target
            pc_load_s  = 1'b1;
            pc_tgt_s   = branch ? ALUResult : redir_tgt_r;
            pend_clr_s = 1'b1;
            state_s    = ST_REQ;
          end else begin
            capture_s = 1'b1;
            state_s   = ST_HOLD;
          end
        end else if (branch) begin
          pend_set_s = 1'b1;
          state_s    = ST_REQ;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (branch) begin
          pc_load_s   = 1'b1;
          clr_valid_s = 1'b1;
          state_s     = ST_REQ;
        end else if (instr_ready) begin
          pc_adv_s    = 1'b1;
          clr_valid_s = 1'b1;
          state_s     = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    req_s = (state_s == ST_REQ);
  end

  // Instruction output register and the one-entry redirect buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r       <= NOP_INSTR;
      instr_pc_r    <= RESET_PC;
      instr_valid_r <= 1'b0;
      redir_pend_r  <= 1'b0;
      redir_tgt_r   <= 32'h0000_0000;
    end else begin
      if (capture_s) begin
        instr_r       <= imem_rdata;
        instr_pc_r    <= pc_s;
        instr_valid_r <= 1'b1;
      end else if (clr_valid_s) begin
        instr_valid_r <= 1'b0;
      end else begin
        instr_valid_r <= instr_valid_r;
      end
      if (pend_clr_s) begin
        redir_pend_r <= 1'b0;
      end else if (pend_set_s) begin
        redir_pend_r <= 1'b1;
        redir_tgt_r  <= ALUResult;
      end else begin
        redir_pend_r <= redir_pend_r;
      end
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_s;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_r;

  // Trap flag: raised by a misaligned redirect, kept until the next instruction lands
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else if (pc_load_s && is_misaligned(pc_tgt_s)) begin
      misalign_r <= 1'b1;
    end else if (capture_s) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign misalign = misalign_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios, then randomized traffic
// scored against a fetch-stream reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        branch;
  logic [31:0] ALUResult;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .branch      (branch),
    .ALUResult   (ALUResult),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign    (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  logic rand_on = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // Monitor: every accepted instruction must be the oldest one the model delivered
  always @(negedge clk) begin
    #1;
    if (rand_on && !rst && instr_valid && instr_ready && !branch) begin
      if (exp_q.size() == 0) begin
        check1("unexpected_accept", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check32("sb_instr", instr, e.ins);
        check32("sb_instr_pc", instr_pc, e.pc);
        n_acc++;
      end
    end
  end

  // Reference model state for the randomized phase
  logic [31:0] fetch_pc;
  logic [31:0] stale_addr;
  logic        stale;
  logic        holding;
  logic        first;
  logic        accepted;
  int          wait_cnt;

  initial begin
    rst = 1'b1; branch = 1'b0; ALUResult = 32'h0; imem_ack = 1'b0;
    imem_rdata = 32'h0; instr_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check32("rst_instr", instr, 32'h0000_0013);
    check32("rst_instr_pc", instr_pc, RST_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
    check1("rst_misalign", misalign, 1'b0);
`endif
    tick();
    check1("first_req", imem_req, 1'b1);
    check32("first_addr", imem_addr, 32'h0000_0100);
    tick();
    check32("first_addr_stable", imem_addr, 32'h0000_0100);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_ack = 1'b0;
    check1("first_valid", instr_valid, 1'b1);
    check32("first_instr", instr, 32'h0050_0093);
    check32("first_instr_pc", instr_pc, 32'h0000_0100);
    check1("hold_no_req", imem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("stall_valid", instr_valid, 1'b1);
      check32("stall_instr", instr, 32'h0050_0093);
      check32("stall_instr_pc", instr_pc, 32'h0000_0100);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check1("seq_valid_clr", instr_valid, 1'b0);
    check1("seq_req", imem_req, 1'b1);
    check32("seq_addr", imem_addr, 32'h0000_0104);
    branch = 1'b1; ALUResult = 32'h0000_0200;
    tick();
    branch = 1'b0;
    check32("pend_addr_held1", imem_addr, 32'h0000_0104);
    tick();
    check32("pend_addr_held2", imem_addr, 32'h0000_0104);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check1("pend_drop_valid", instr_valid, 1'b0);
    check1("pend_req", imem_req, 1'b1);
    check32("pend_new_addr", imem_addr, 32'h0000_0200);
    branch = 1'b1; ALUResult = 32'h0000_03FE; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    branch = 1'b0; imem_ack = 1'b0;
    check1("same_drop_valid", instr_valid, 1'b0);
    check32("same_addr", imem_addr, 32'h0000_03FC);
`ifdef FETCH_MISALIGN_TRAP_EN
    check1("misalign_set", misalign, 1'b1);
`endif
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    check1("aligned_valid", instr_valid, 1'b1);
    check32("aligned_instr_pc", instr_pc, 32'h0000_03FC);
`ifdef FETCH_MISALIGN_TRAP_EN
    check1("misalign_clr", misalign, 1'b0);
`endif
    branch = 1'b1; ALUResult = 32'hFFFF_FFFC; instr_ready = 1'b1;
    tick();
    branch = 1'b0; instr_ready = 1'b0;
    check1("prio_valid", instr_valid, 1'b0);
    check32("prio_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
    tick();
    imem_ack = 1'b0;
    check32("top_instr_pc", instr_pc, 32'hFFFF_FFFC);
    check32("top_instr", instr, 32'hAAAA_0001);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check1("wrap_req", imem_req, 1'b1);
    check32("wrap_addr", imem_addr, 32'h0000_0000);
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    check1("midrst_req", imem_req, 1'b0);
    check1("midrst_valid", instr_valid, 1'b0);
    check32("midrst_addr", imem_addr, RST_PC);
    tick();
    imem_ack = 1'b0;
    check1("midrst_ack_ignored", instr_valid, 1'b0);
    check1("midrst_restart_req", imem_req, 1'b1);
    check32("midrst_restart_addr", imem_addr, RST_PC);

    // Randomized phase
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    fetch_pc = RST_PC; stale = 1'b0; stale_addr = 32'h0; holding = 1'b0;
    first = 1'b1; wait_cnt = 0;
    exp_q.delete();
    rand_on = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      check1("rnd_req", imem_req, first ? 1'b0 : !holding);
      check1("rnd_valid", instr_valid, holding);
      if (imem_req) begin
        check32("rnd_addr", imem_addr, stale ? stale_addr : fetch_pc);
      end
      branch      = ($urandom_range(0, 7) == 0);
      ALUResult   = $urandom;
      instr_ready = ($urandom_range(0, 2) != 0);
      imem_ack    = 1'b0;
      if (imem_req) begin
        if (wait_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = $urandom_range(0, 3);
        end else begin
          wait_cnt = wait_cnt - 1;
        end
      end
      accepted = holding && instr_ready && !branch;
      if (branch) begin
        if (holding) begin
          void'(exp_q.pop_back());
          holding = 1'b0;
        end
        if (imem_req && !imem_ack && !stale) begin
          stale      = 1'b1;
          stale_addr = fetch_pc;
        end
        fetch_pc = ALUResult & 32'hFFFF_FFFC;
      end
      if (imem_req && imem_ack) begin
        if (!branch && !stale) begin
          exp_q.push_back('{pc: fetch_pc, ins: imem_rdata});
          holding = 1'b1;
        end
        stale = 1'b0;
      end
      if (accepted) begin
        holding  = 1'b0;
        fetch_pc = fetch_pc + 32'd4;
      end
      first = 1'b0;
      tick();
    end
    rand_on = 1'b0;
    branch = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    check1("rnd_progress", n_acc >= 200, 1'b1);
    check1("rnd_queue_drained", exp_q.size() <= 1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
